// File: rtl/mesi_seq_driver.sv
// Transmit-side driver for the MESI snoop detector: buffers upstream beats in a
// small FIFO and serializes them onto r_w/inbits, inserting idle symbols between frames.
module mesi_seq_driver #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [1:0]  cmd_bits,
    input  logic        cmd_last,
    input  logic        bus_stall,
    output logic        r_w,
    output logic [1:0]  inbits,
    output logic        bus_valid,
    output logic        busy,
    output logic [15:0] beat_count
);

    // state  | meaning
    // S_IDLE | bus idle, waiting for a buffered beat
    // S_SEND | popping one beat per cycle onto the bus
    // S_GAP  | emitting idle symbols after a frame's last beat
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, empty, full;
    logic [3:0]    head;

    state_t        state_q, state_d;
    logic [3:0]    gap_q, gap_d;
    logic          rw_q, rw_d;
    logic [1:0]    bits_q, bits_d;
    logic          valid_q, valid_d;
    logic [15:0]   beat_cnt_q, beat_cnt_d;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        rw_d       = rw_q;
        bits_d     = bits_q;
        valid_d    = valid_q;
        beat_cnt_d = beat_cnt_q;
        pop        = 1'b0;
        if (!bus_stall) begin
            case (state_q)
                S_IDLE: begin
                    rw_d    = 1'b1;
                    bits_d  = 2'b00;
                    valid_d = 1'b0;
                    if (!empty) state_d = S_SEND;
                end
                S_SEND: begin
                    if (!empty) begin
                        pop        = 1'b1;
                        rw_d       = head[3];
                        bits_d     = head[2:1];
                        valid_d    = 1'b1;
                        beat_cnt_d = beat_cnt_q + 16'd1;
                        if (head[0] && GAP != 0) begin
                            gap_d   = 4'(GAP);
                            state_d = S_GAP;
                        end
                    end else begin
                        // underrun mid-frame: park the detector on the idle symbol
                        rw_d    = 1'b1;
                        bits_d  = 2'b00;
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_GAP: begin
                    rw_d    = 1'b1;
                    bits_d  = 2'b00;
                    valid_d = 1'b0;
                    gap_d   = gap_q - 4'd1;
                    if (gap_q == 4'd1) state_d = empty ? S_IDLE : S_SEND;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            gap_q      <= '0;
            rw_q       <= 1'b1;
            bits_q     <= 2'b00;
            valid_q    <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {cmd_rw, cmd_bits, cmd_last};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            state_q    <= state_d;
            gap_q      <= gap_d;
            rw_q       <= rw_d;
            bits_q     <= bits_d;
            valid_q    <= valid_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign r_w        = rw_q;
    assign inbits     = bits_q;
    assign bus_valid  = valid_q;
    assign beat_count = beat_cnt_q;
    assign busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_mesi_seq_driver.sv
// Scoreboard bench for mesi_seq_driver: stimulus pushes beats into a model queue,
// a monitor predicts each bus cycle from the frame/gap rules and compares.
module tb_mesi_seq_driver;
    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int M_IDLE = 0, M_SEND = 1, M_GAP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_rw = 1'b0, cmd_last = 1'b0, bus_stall = 1'b0;
    logic [1:0]  cmd_bits = 2'b00;
    logic        cmd_ready, r_w, bus_valid, busy;
    logic [1:0]  inbits;
    logic [15:0] beat_count;

    int checks = 0, failures = 0;
    bit rand_stall = 0;

    // expected model
    logic [3:0]  q[$];
    int          mode = M_IDLE, gap_left = 0;
    logic        e_rw = 1'b1, e_valid = 1'b0;
    logic [1:0]  e_bits = 2'b00;
    logic [15:0] e_cnt = 16'd0;

    mesi_seq_driver #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_bits(cmd_bits), .cmd_last(cmd_last), .bus_stall(bus_stall),
        .r_w(r_w), .inbits(inbits), .bus_valid(bus_valid), .busy(busy), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always begin
        int       n;
        bit       push_e, stall_e;
        logic [3:0] pbeat, hd;
        @(posedge clk);
        if (!reset) begin
            q.delete();
            mode = M_IDLE; gap_left = 0;
            e_rw = 1'b1; e_bits = 2'b00; e_valid = 1'b0; e_cnt = 16'd0;
        end else begin
            n       = q.size();
            push_e  = cmd_valid && cmd_ready;
            stall_e = bus_stall;
            pbeat   = {cmd_rw, cmd_bits, cmd_last};
            check("cmd_ready", {31'd0, cmd_ready}, {31'd0, n < DEPTH});
            if (!stall_e) begin
                case (mode)
                    M_IDLE: begin
                        e_rw = 1'b1; e_bits = 2'b00; e_valid = 1'b0;
                        if (n > 0) mode = M_SEND;
                    end
                    M_SEND: begin
                        if (n > 0) begin
                            hd = q.pop_front();
                            e_rw = hd[3]; e_bits = hd[2:1]; e_valid = 1'b1;
                            e_cnt = e_cnt + 16'd1;
                            if (hd[0] && GAP > 0) begin mode = M_GAP; gap_left = GAP; end
                        end else begin
                            e_rw = 1'b1; e_bits = 2'b00; e_valid = 1'b0;
                            mode = M_IDLE;
                        end
                    end
                    default: begin
                        e_rw = 1'b1; e_bits = 2'b00; e_valid = 1'b0;
                        gap_left--;
                        if (gap_left == 0) mode = (n > 0) ? M_SEND : M_IDLE;
                    end
                endcase
            end
            if (push_e) q.push_back(pbeat);
            #1;
            check("r_w", {31'd0, r_w}, {31'd0, e_rw});
            check("inbits", {30'd0, inbits}, {30'd0, e_bits});
            check("bus_valid", {31'd0, bus_valid}, {31'd0, e_valid});
            check("beat_count", {16'd0, beat_count}, {16'd0, e_cnt});
            check("busy", {31'd0, busy}, {31'd0, (mode != M_IDLE) || (q.size() != 0)});
        end
    end

    // called at a negedge; returns at the negedge after the beat was accepted
    task automatic send_beat(input logic rw, input logic [1:0] b, input logic last, output int waited);
        bit acc;
        waited = 0;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_bits = b; cmd_last = last;
        do begin
            @(posedge clk);
            acc = cmd_ready;
            waited++;
            @(negedge clk);
            if (rand_stall) bus_stall = ($urandom_range(0, 4) == 0);
        end while (!acc && waited < 200);
        check("accept_in_time", {31'd0, acc}, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            if (rand_stall) bus_stall = ($urandom_range(0, 4) == 0);
        end
    endtask

    task automatic drain();
        int t = 0;
        bus_stall = 1'b0;
        while ((q.size() != 0 || mode != M_IDLE) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", {31'd0, t < 500}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int w;
        logic [15:0] base;
        int n;
        // reset held with cmd_valid asserted
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_bits = 2'b10; cmd_last = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_r_w", {31'd0, r_w}, 32'd1);
            check("rst_inbits", {30'd0, inbits}, 32'd0);
            check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
            check("rst_beat_count", {16'd0, beat_count}, 32'd0);
            check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        cmd_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // latency and gap: frame {1,11,0},{1,11,1}
        base = e_cnt;
        send_beat(1'b1, 2'b11, 1'b0, w);
        send_beat(1'b1, 2'b11, 1'b1, w);
        @(posedge clk); #1;
        check("lat_first_valid", {31'd0, bus_valid}, 32'd1);
        check("lat_first_bits", {29'd0, r_w, inbits}, 32'h7);
        @(posedge clk); #1;
        check("lat_second_valid", {31'd0, bus_valid}, 32'd1);
        @(posedge clk); #1;
        check("gap_idle_valid", {31'd0, bus_valid}, 32'd0);
        check("gap_idle_sym", {29'd0, r_w, inbits}, 32'h4);
        check("frame_count", {16'd0, beat_count}, {16'd0, base + 16'd2});
        drain();

        // full FIFO under stall
        bus_stall = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(i[0], i[1:0] ^ 2'b01, i == 3, w);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_bits = 2'b10; cmd_last = 1'b1;
        #1 check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("full_ready_held", {31'd0, cmd_ready}, 32'd0);
        bus_stall = 1'b0;
        send_beat(1'b0, 2'b10, 1'b1, w);
        check("fifth_accept_edge", w, 32'd3);
        drain();

        // stall mid-frame
        base = e_cnt;
        send_beat(1'b0, 2'b01, 1'b0, w);
        send_beat(1'b1, 2'b10, 1'b0, w);
        send_beat(1'b0, 2'b11, 1'b1, w);
        bus_stall = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_count", {16'd0, beat_count}, {16'd0, base + 16'd1});
            check("stall_bits", {29'd0, r_w, inbits}, 32'h1);
            check("stall_valid", {31'd0, bus_valid}, 32'd1);
        end
        @(negedge clk);
        drain();
        check("stall_total", {16'd0, beat_count}, {16'd0, base + 16'd3});

        // underrun
        base = e_cnt;
        send_beat(1'b0, 2'b01, 1'b0, w);
        repeat (5) @(negedge clk);
        check("under_count", {16'd0, beat_count}, {16'd0, base + 16'd1});
        check("under_valid", {31'd0, bus_valid}, 32'd0);
        check("under_sym", {29'd0, r_w, inbits}, 32'h4);
        check("under_busy", {31'd0, busy}, 32'd0);

        // randomized traffic with random stalls
        rand_stall = 1;
        for (int i = 0; i < 400; i++) begin
            send_beat(1'($urandom), 2'($urandom), $urandom_range(0, 3) == 0, w);
            if ($urandom_range(0, 5) == 0) idle_cycles($urandom_range(1, 6));
        end
        rand_stall = 0;
        drain();

        // beat_count wrap
        n = 65535 - int'(e_cnt);
        for (int i = 0; i < n; i++) send_beat(1'($urandom), 2'($urandom), 1'b0, w);
        drain();
        check("count_ffff", {16'd0, beat_count}, 32'hFFFF);
        send_beat(1'b1, 2'b10, 1'b1, w);
        drain();
        check("count_wrap", {16'd0, beat_count}, 32'h0);

        // asynchronous reset mid-frame
        send_beat(1'b0, 2'b11, 1'b0, w);
        send_beat(1'b0, 2'b10, 1'b0, w);
        send_beat(1'b1, 2'b01, 1'b1, w);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus_valid}, 32'd0);
        check("arst_sym", {29'd0, r_w, inbits}, 32'h4);
        check("arst_count", {16'd0, beat_count}, 32'd0);
        check("arst_ready", {31'd0, cmd_ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_resume", {16'd0, beat_count}, 32'd0);
        check("arst_idle_valid", {31'd0, bus_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mesi_seq_driver.md
Name: mesi_seq_driver

Overview:
- Transmit-side counterpart of the MESI snoop sequence detector.
- Accepts snoop beats ({r_w, inbits[1:0]}, plus an end-of-frame marker) from the trace/testbench side over a valid/ready handshake and buffers them in a small FIFO.
- Serializes them one beat per cycle onto the detector's r_w/inbits bus.
- After each frame it emits a programmable number of idle (resync) symbols, so the downstream detector always returns to its initial state between frames.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- GAP, 1, idle symbols emitted after each frame's last beat; 0..15; 0 means no gap.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  upstream beat valid.
- cmd_ready  output  1  FIFO can accept a beat; equals !full (combinational).
- cmd_rw  input  1  beat r_w value.
- cmd_bits  input  2  beat inbits value.
- cmd_last  input  1  beat is the last beat of its frame.
- bus_stall  input  1  downstream pause; freezes the transmit side.
- r_w  output  1  registered r_w to the detector.
- inbits  output  2  registered inbits to the detector.
- bus_valid  output  1  registered; high when r_w/inbits carry a real beat.
- busy  output  1  (state != IDLE) or FIFO non-empty; combinational.
- beat_count  output  16  registered count of beats emitted.

Behaviour:
- Idle symbol: r_w=1, inbits=2'b00. This returns the detector to its initial state from any state.
- Reset (reset=0, asynchronous), all of the following take effect immediately and hold until reset=1:
  - r_w=1, inbits=00, bus_valid=0, beat_count=0.
  - FIFO emptied (pointers and count = 0); cmd_ready=1, busy=0.
  - FSM=IDLE, gap counter=0.
  - Reset mid-frame discards all buffered beats. No further beats are emitted for that frame.
- FIFO:
  - Push when cmd_valid && cmd_ready. Each entry stores {cmd_rw, cmd_bits, cmd_last}.
  - Pop only as described under SEND.
  - Push and pop in the same cycle: both occur and count is unchanged.
  - No bypass: a beat pushed into an empty FIFO is visible to the FSM the next cycle.
  - Pointers wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits.
- FSM states: IDLE, SEND, GAP. All transitions and output updates happen only on edges where bus_stall=0.
- bus_stall=1:
  - FSM, r_w, inbits, bus_valid, beat_count and gap counter all hold.
  - FIFO pushes continue; no pops.
- IDLE:
  - FIFO empty: drive idle symbol, bus_valid=0.
  - FIFO non-empty: go to SEND and do not pop this edge.
- SEND, FIFO non-empty:
  - Pop head; r_w<=head.rw, inbits<=head.bits, bus_valid<=1, beat_count<=beat_count+1. beat_count wraps FFFF->0000.
  - If head.last and GAP>0: gap counter<=GAP, go to GAP.
  - If head.last and GAP=0: stay in SEND.
- SEND, FIFO empty (underrun mid-frame): drive idle symbol, bus_valid<=0, go to IDLE.
- GAP:
  - Each edge drives the idle symbol with bus_valid<=0 and decrements the gap counter.
  - On the edge where the counter is 1, go to SEND if the FIFO is non-empty, else IDLE.
  - Exactly GAP idle cycles appear on the bus. FIFO beats are not popped during GAP.
- Latency: beat accepted at edge E into an empty FIFO in IDLE with no stall → FSM enters SEND at E+1 → beat appears on r_w/inbits with bus_valid=1 after edge E+2.
- Throughput: one beat per non-stalled cycle while the FIFO is non-empty within a frame.
- Illegal cases: none. Every {r_w, inbits} value is transmitted verbatim.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 → r_w=1, inbits=00, bus_valid=0, beat_count=0, cmd_ready=1, busy=0, no push retained.
- Detect frame, GAP=1: push {1,11,0} then {1,11,1} on consecutive edges → bus carries (1,11), (1,11) with bus_valid=1 starting 2 cycles after the first push, then one idle cycle → a connected detector asserts detect once. beat_count=2.
- Full FIFO, DEPTH=4: bus_stall=1, present 5 beats → first 4 accepted, cmd_ready=0 after the 4th push. Release stall → the 5th beat is accepted the cycle after the first pop. Bus order matches push order.
- Stall mid-frame: assert bus_stall for 3 cycles after the first beat of a 3-beat frame → r_w/inbits/bus_valid/beat_count frozen for those cycles; remaining beats follow without loss.
- Underrun: push {0,01,0}, then nothing → one valid beat, then idle symbol with bus_valid=0, FSM back in IDLE, busy=0.
- Wrap/async reset: preload beat_count to FFFF via 65535 beats, send 1 more → 0000. Assert reset asynchronously mid-frame → outputs return to reset values before the next clock edge.
